// File: rtl/spi_bus_pkg.sv
// Shared constants for the memory-mapped SPI master: register offsets,
// STATUS/CONTROL bit positions, FSM encoding and the CONTROL register layout.
package spi_bus_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;

    localparam int ST_BUSY_BIT    = 0;
    localparam int ST_RXVALID_BIT = 1;
    localparam int ST_OVERRUN_BIT = 2;

    localparam int CTL_CPOL_BIT = 0;
    localparam int CTL_CPHA_BIT = 1;
    localparam int CTL_SS_BIT   = 2;
    localparam int CTL_DIV_LSB  = 8;
    localparam int CTL_DIV_MSB  = 15;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    typedef struct packed {
        logic [7:0] div;
        logic       ss_active;
        logic       cpha;
        logic       cpol;
    } spi_ctrl_t;

    function automatic logic [31:0] ctrl_word(input spi_ctrl_t c);
        return {16'b0, c.div, 5'b0, c.ss_active, c.cpha, c.cpol};
    endfunction

endpackage

// File: rtl/spi_edge_generator.sv
// SCLK generator: toggles sclk every div+1 cycles while run is high and flags
// leading/trailing edges plus the final (2*DATA_BITS-th) edge of a transfer.
module spi_edge_generator
#(
    parameter int DATA_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       cpol,
    input  logic [7:0] div,
    output logic       sclk,
    output logic       lead_pulse,
    output logic       trail_pulse,
    output logic       done_pulse
);

    localparam int EW = $clog2(2 * DATA_BITS);

    logic [7:0]    hcnt_q, hcnt_d;
    logic [EW-1:0] ecnt_q, ecnt_d;
    logic          sclk_q, sclk_d;
    logic          tick;

    // The pulses are asserted in the cycle whose closing clock edge moves sclk.
    assign tick        = run && (hcnt_q == div);
    assign lead_pulse  = tick && !ecnt_q[0];
    assign trail_pulse = tick && ecnt_q[0];
    assign done_pulse  = tick && (ecnt_q == EW'(2 * DATA_BITS - 1));
    assign sclk        = sclk_q;

    always_comb begin
        hcnt_d = hcnt_q;
        ecnt_d = ecnt_q;
        sclk_d = sclk_q;
        if (!run) begin
            hcnt_d = '0;
            ecnt_d = '0;
            sclk_d = cpol;
        end else if (tick) begin
            hcnt_d = '0;
            ecnt_d = ecnt_q + 1'b1;
            sclk_d = ~sclk_q;
        end else begin
            hcnt_d = hcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_q <= '0;
            ecnt_q <= '0;
            sclk_q <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            ecnt_q <= ecnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_bus_master.sv
// Bus-attached SPI master: DATA/STATUS/CONTROL registers, transfer FSM and
// shift register; SCLK timing comes from spi_edge_generator.
module spi_bus_master
    import spi_bus_pkg::*;
#(
    parameter logic [7:0] DEFAULT_DIV = 8'd49,
    parameter int         DATA_BITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        oe,
    input  logic [3:0]  we,
    input  logic [1:0]  address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        data_oe,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        ss_n,
    output logic        busy
);

    logic [1:0]           state_q, state_d;
    spi_ctrl_t            ctrl_q, ctrl_d;
    logic [DATA_BITS-1:0] sreg_q, sreg_d;
    logic [DATA_BITS-1:0] rx_q, rx_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 overrun_q, overrun_d;
    logic                 mosi_q, mosi_d;
    logic                 rd_q;

    logic wr, data_wr, data_rd, run;
    logic lead, trail, done_pulse;
    logic sample_edge, shift_edge;
    logic unused_bits;

    assign wr      = cs && (|we);
    assign data_wr = wr && (address == ADDR_DATA);
    assign data_rd = cs && oe && (address == ADDR_DATA);
    assign run     = (state_q == S_SHIFT);

    assign data_oe = cs & oe;
    assign busy    = (state_q != S_IDLE);
    assign ss_n    = ~ctrl_q.ss_active;
    assign mosi    = mosi_q;
    assign unused_bits = ^data_in[31:16];

    spi_edge_generator #(
        .DATA_BITS (DATA_BITS)
    ) u_edge (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .cpol        (ctrl_q.cpol),
        .div         (ctrl_q.div),
        .sclk        (sclk),
        .lead_pulse  (lead),
        .trail_pulse (trail),
        .done_pulse  (done_pulse)
    );

    // cpha selects which edge samples miso and which one advances mosi.
    assign sample_edge = ctrl_q.cpha ? trail : lead;
    assign shift_edge  = ctrl_q.cpha ? lead  : (trail && !done_pulse);

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        sreg_d     = sreg_q;
        rx_d       = rx_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        mosi_d     = mosi_q;

        if (data_rd && !rd_q)
            rx_valid_d = 1'b0;
        if (wr && (address == ADDR_STATUS) && data_in[ST_OVERRUN_BIT])
            overrun_d = 1'b0;
        // ss_active stays writable mid-transfer so CS can span several bytes.
        if (wr && (address == ADDR_CONTROL)) begin
            ctrl_d.ss_active = data_in[CTL_SS_BIT];
            if (state_q == S_IDLE) begin
                ctrl_d.cpol = data_in[CTL_CPOL_BIT];
                ctrl_d.cpha = data_in[CTL_CPHA_BIT];
                ctrl_d.div  = data_in[CTL_DIV_MSB:CTL_DIV_LSB];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (data_wr) begin
                    sreg_d  = data_in[DATA_BITS-1:0];
                    state_d = S_SHIFT;
                    if (!ctrl_q.cpha)
                        mosi_d = data_in[DATA_BITS-1];
                end
            end
            S_SHIFT: begin
                if (data_wr)
                    overrun_d = 1'b1;
                if (sample_edge)
                    sreg_d = {sreg_q[DATA_BITS-2:0], miso};
                if (shift_edge)
                    mosi_d = sreg_q[DATA_BITS-1];
                if (done_pulse)
                    state_d = S_DONE;
            end
            S_DONE: begin
                rx_d       = sreg_q;
                rx_valid_d = 1'b1;
                if (rx_valid_q || data_wr)
                    overrun_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_out = '0;
        case (address)
            ADDR_DATA:    data_out[DATA_BITS-1:0] = rx_q;
            ADDR_STATUS: begin
                data_out[ST_BUSY_BIT]    = busy;
                data_out[ST_RXVALID_BIT] = rx_valid_q;
                data_out[ST_OVERRUN_BIT] = overrun_q;
            end
            ADDR_CONTROL: data_out = ctrl_word(ctrl_q);
            default:      data_out = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ctrl_q     <= '{div: DEFAULT_DIV, default: 1'b0};
            sreg_q     <= '0;
            rx_q       <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            mosi_q     <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            sreg_q     <= sreg_d;
            rx_q       <= rx_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            mosi_q     <= mosi_d;
            rd_q       <= data_rd;
        end
    end

endmodule

// File: tb/tb_spi_bus_master.sv
// Directed + randomized bench for spi_bus_master with a behavioural SPI slave
// that follows the four SPI modes directly from sclk/cpol/cpha.
module tb_spi_bus_master;
    import spi_bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0;
    logic        oe = 1'b0;
    logic [3:0]  we = 4'h0;
    logic [1:0]  address = 2'd0;
    logic [31:0] data_in = 32'h0;
    logic [31:0] data_out;
    logic        data_oe, sclk, mosi, ss_n, busy;
    logic        miso_w;

    logic        loop = 1'b0;
    logic        s_miso = 1'b0;
    logic        slave_en = 1'b0;
    logic        m_cpol = 1'b0;
    logic        m_cpha = 1'b0;
    logic [7:0]  s_tx = 8'h0;
    logic [7:0]  s_rx = 8'h0;
    int          s_idx = 0;
    int          s_cnt = 0;

    int vectors = 0;
    int miscompares = 0;

    assign miso_w = loop ? mosi : s_miso;

    always #5 clk = ~clk;

    spi_bus_master dut (
        .clk      (clk),
        .rst      (rst_n),
        .cs       (cs),
        .oe       (oe),
        .we       (we),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso_w),
        .ss_n     (ss_n),
        .busy     (busy)
    );

    // Slave: leading edge = sclk leaving idle level; sample edge is leading
    // for cpha=0 and trailing for cpha=1, the other edge drives miso.
    always @(sclk) begin
        if (slave_en) begin
            if ((sclk !== m_cpol) ^ m_cpha) begin
                s_rx = {s_rx[6:0], mosi};
                s_cnt++;
            end else if (s_idx < 8) begin
                s_miso = s_tx[3'(7 - s_idx)];
                s_idx++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1; we = 4'hF; address = a; data_in = d;
        @(negedge clk);
        cs = 1'b0; we = 4'h0; data_in = 32'h0;
    endtask

    task automatic read_now(input logic [1:0] a, output logic [31:0] v);
        cs = 1'b1; oe = 1'b1; address = a;
        #1 v = data_out;
        @(negedge clk);
        cs = 1'b0; oe = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] v;
        read_now(a, v);
        check(tag, v, exp);
        $display("read  %-14s addr=%0d data=0x%08h", tag, a, v);
    endtask

    task automatic set_ctrl(input logic [31:0] v);
        bus_write(ADDR_CONTROL, v);
        m_cpol = v[0];
        m_cpha = v[1];
        @(negedge clk);
        $display("ctrl  write 0x%08h", v);
    endtask

    task automatic slave_arm(input logic [7:0] stx);
        s_tx = stx; s_rx = 8'h0; s_cnt = 0;
        s_idx  = m_cpha ? 0 : 1;
        s_miso = m_cpha ? 1'b0 : stx[7];
        slave_en = 1'b1;
    endtask

    // Expected timing: write accepted at N, DONE in N+16*(div+1)+1, idle after.
    task automatic run_xfer(input logic [7:0] tx, input logic [7:0] stx, input int dv, input bit rd_done);
        slave_arm(stx);
        bus_write(ADDR_DATA, {24'h0, tx});
        repeat (16 * (dv + 1)) @(negedge clk);
        check("done_busy", busy, 1);
        if (rd_done) begin cs = 1'b1; oe = 1'b1; address = ADDR_DATA; end
        @(negedge clk);
        cs = 1'b0; oe = 1'b0;
        check("idle_busy", busy, 0);
        check("sclk_rest", sclk, m_cpol);
        check("slave_rx", s_rx, tx);
        check("slave_edges", s_cnt, 8);
        slave_en = 1'b0;
        $display("xfer  tx=0x%02h slave_tx=0x%02h div=%0d cpol=%0b cpha=%0b slave_got=0x%02h",
                 tx, stx, dv, m_cpol, m_cpha, s_rx);
    endtask

    initial begin
        logic [7:0]  t1, t2, b1, b2;
        logic [31:0] cw;
        int          dv;

        // Power-on reset
        @(negedge clk);
        check("rst_sclk", sclk, 0);
        check("rst_ssn", ss_n, 1);
        check("rst_busy", busy, 0);
        check("rst_mosi", mosi, 0);
        read_check("rst_control", ADDR_CONTROL, 32'h0000_3100);
        read_check("rst_status", ADDR_STATUS, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a transfer
        set_ctrl(32'h0000_3105);
        bus_write(ADDR_DATA, 32'h5A);
        repeat (60) @(negedge clk);
        check("mid_busy", busy, 1);
        check("mid_ssn", ss_n, 0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_sclk", sclk, 0);
        check("abort_ssn", ss_n, 1);
        check("abort_busy", busy, 0);
        m_cpol = 1'b0; m_cpha = 1'b0;
        @(negedge clk);
        read_check("abort_control", ADDR_CONTROL, 32'h0000_3100);
        read_check("abort_status", ADDR_STATUS, 32'h0);
        read_check("abort_data", ADDR_DATA, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Mode 0 loopback at div=0: slave sees mosi bits 1,0,1,0,0,1,0,1
        loop = 1'b1;
        set_ctrl(32'h0000_0000);
        run_xfer(8'hA5, 8'h00, 0, 1'b0);
        read_check("m0_status", ADDR_STATUS, 32'h2);
        read_check("m0_data", ADDR_DATA, 32'hA5);
        read_check("m0_status_clr", ADDR_STATUS, 32'h0);
        loop = 1'b0;

        // Mode 3 with slave returning 0x3C, CS asserted
        set_ctrl(32'h0000_0107);
        check("m3_sclk_idle", sclk, 1);
        check("m3_ssn", ss_n, 0);
        run_xfer(8'hC3, 8'h3C, 1, 1'b0);
        check("m3_ssn_after", ss_n, 0);
        read_check("m3_status", ADDR_STATUS, 32'h2);
        read_check("m3_data", ADDR_DATA, 32'h3C);

        // Overrun by a second DATA write; CONTROL write mid-transfer only moves ss
        set_ctrl(32'h0000_0004);
        slave_arm(8'h96);
        bus_write(ADDR_DATA, 32'h11);
        repeat (2) @(negedge clk);
        bus_write(ADDR_DATA, 32'h22);
        bus_write(ADDR_CONTROL, 32'h0000_FF03);
        repeat (20) @(negedge clk);
        check("ovw_busy", busy, 0);
        check("ovw_slave_rx", s_rx, 8'h11);
        check("ovw_slave_edges", s_cnt, 8);
        check("ovw_ssn", ss_n, 1);
        check("ovw_sclk", sclk, 0);
        slave_en = 1'b0;
        read_check("ovw_status", ADDR_STATUS, 32'h6);
        read_check("ovw_control", ADDR_CONTROL, 32'h0);
        read_check("ovw_data", ADDR_DATA, 32'h96);
        bus_write(ADDR_STATUS, 32'h4);
        read_check("ovw_cleared", ADDR_STATUS, 32'h0);

        // Overrun by two transfers with no DATA read in between
        t1 = 8'($urandom); t2 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
        run_xfer(t1, b1, 0, 1'b0);
        read_check("ovr_status1", ADDR_STATUS, 32'h2);
        run_xfer(t2, b2, 0, 1'b0);
        read_check("ovr_status2", ADDR_STATUS, 32'h6);
        read_check("ovr_data", ADDR_DATA, {24'h0, b2});
        bus_write(ADDR_STATUS, 32'h4);
        read_check("ovr_cleared", ADDR_STATUS, 32'h0);

        // DATA read in the DONE cycle, then a held 3-cycle read
        t1 = 8'($urandom); b1 = 8'($urandom);
        run_xfer(t1, b1, 0, 1'b1);
        read_check("col_status", ADDR_STATUS, 32'h2);
        cs = 1'b1; oe = 1'b1; address = ADDR_DATA;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("held_oe", data_oe, 1);
            check("held_data", data_out, {24'h0, b1});
            @(negedge clk);
        end
        cs = 1'b0; oe = 1'b0;
        #1 check("oe_released", data_oe, 0);
        @(negedge clk);
        read_check("held_status", ADDR_STATUS, 32'h0);

        // Slowest divider
        set_ctrl(32'h0000_FF00);
        t1 = 8'($urandom); b1 = 8'($urandom);
        run_xfer(t1, b1, 255, 1'b0);
        read_check("div255_status", ADDR_STATUS, 32'h2);
        read_check("div255_data", ADDR_DATA, {24'h0, b1});

        // Randomized modes, dividers and bytes
        for (int i = 0; i < 6; i++) begin
            dv = int'($urandom_range(0, 2));
            cw = {16'h0, 8'(dv), 5'b0, 1'($urandom), 1'($urandom), 1'($urandom)};
            set_ctrl(cw);
            read_check("rnd_control", ADDR_CONTROL, cw);
            t1 = 8'($urandom); b1 = 8'($urandom);
            run_xfer(t1, b1, dv, 1'b0);
            read_check("rnd_status", ADDR_STATUS, 32'h2);
            read_check("rnd_data", ADDR_DATA, {24'h0, b1});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
